// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI register sequencer: table entry layout,
// op encodings, SPI instruction header bit positions and FSM states.
package spi_seq_pkg;

    localparam int unsigned ENTRY_W  = 32;
    localparam int unsigned SPI_W    = 24;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DLY_W    = 24;

    localparam int unsigned RNW_BIT  = 23;
    localparam int unsigned W1W0_HI  = 22;
    localparam int unsigned W1W0_LO  = 21;
    localparam int unsigned HADDR_HI = 20;
    localparam int unsigned HADDR_LO = 8;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'b00,
        OP_WRITE_VERIFY = 2'b01,
        OP_DELAY        = 2'b10,
        OP_END          = 2'b11
    } op_e;

    typedef struct packed {
        op_e               op;
        logic              rsvd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } entry_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_WR_REQ  = 4'd3,
        S_WR_BUSY = 4'd4,
        S_WR_DONE = 4'd5,
        S_RD_REQ  = 4'd6,
        S_RD_BUSY = 4'd7,
        S_RD_DONE = 4'd8,
        S_CHECK   = 4'd9,
        S_DELAY   = 4'd10,
        S_NEXT    = 4'd11,
        S_DONE    = 4'd12,
        S_ERROR   = 4'd13
    } seq_state_e;

    // Build the 24-bit spi_master word: {R/nW, W1W0=00, addr, data}.
    function automatic logic [SPI_W-1:0] spi_word(input logic              rnw,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data);
        logic [SPI_W-1:0] w;
        w                   = '0;
        w[RNW_BIT]          = rnw;
        w[W1W0_HI:W1W0_LO]  = 2'b00;
        w[HADDR_HI:HADDR_LO] = addr;
        w[DATA_W-1:0]       = data;
        return w;
    endfunction

endpackage

// File: rtl/spi_reg_sequencer.sv
// Table-driven SPI register programmer: walks a sync-ROM register table, issues
// writes to spi_master, optionally reads back and verifies, and runs timed delays.
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned TBL_AW       = 6,
    parameter int unsigned BUSY_TIMEOUT = 4096,
    parameter int unsigned VERIFY_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_start,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic [TBL_AW-1:0] o_err_index,
    output logic [TBL_AW-1:0] o_tbl_addr,
    input  logic [31:0]       i_tbl_data,
    output logic              o_spi_wr_cmd,
    output logic              o_spi_rd_cmd,
    output logic [23:0]       o_spi_wr_data,
    input  logic [7:0]        i_spi_rd_data,
    input  logic              i_spi_busy
);

    localparam int unsigned TMO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned RTY_W  = (VERIFY_RETRY > 0) ? $clog2(VERIFY_RETRY + 1) : 1;
    localparam int unsigned DLY_CW = DLY_W + 1;
    localparam logic [TBL_AW-1:0] LAST_ADDR = '1;

    seq_state_e         r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [TBL_AW-1:0]  r_err_index;
    logic [TBL_AW-1:0]  r_tbl_addr;
    logic               r_wr_cmd;
    logic               r_rd_cmd;
    logic [SPI_W-1:0]   r_spi_word;
    op_e                r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_mask;
    logic [DLY_W-1:0]   r_dly_len;
    logic [DLY_W-1:0]   r_dly_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [RTY_W-1:0]   r_rty_cnt;
    logic [DATA_W-1:0]  r_rd_byte;

    entry_t             w_entry;
    logic               w_unused_rsvd;
    logic               w_tmo_hit;
    logic               w_check_pass;
    logic               w_retry_left;
    logic               w_dly_last;

    assign w_entry       = entry_t'(i_tbl_data);
    assign w_unused_rsvd = w_entry.rsvd;
    assign w_tmo_hit     = (r_tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));
    assign w_check_pass  = (((r_rd_byte ^ r_data) & r_mask) == '0);
    assign w_retry_left  = (r_rty_cnt < RTY_W'(VERIFY_RETRY));
    // A zero-length delay still spends one cycle in S_DELAY.
    assign w_dly_last    = (({1'b0, r_dly_cnt} + DLY_CW'(1)) >= {1'b0, r_dly_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_index <= '0;
            r_tbl_addr  <= '0;
            r_wr_cmd    <= 1'b0;
            r_rd_cmd    <= 1'b0;
            r_spi_word  <= '0;
            r_op        <= OP_WRITE;
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_dly_len   <= '0;
            r_dly_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_rty_cnt   <= '0;
            r_rd_byte   <= '0;
        end else begin
            r_wr_cmd <= 1'b0;
            r_rd_cmd <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_cfg_start) begin
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_tbl_addr <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_op      <= w_entry.op;
                    r_addr    <= w_entry.addr;
                    r_data    <= w_entry.data;
                    r_mask    <= w_entry.mask;
                    r_dly_len <= i_tbl_data[DLY_W-1:0];
                    r_dly_cnt <= '0;
                    r_rty_cnt <= '0;
                    case (w_entry.op)
                        OP_WRITE, OP_WRITE_VERIFY: begin
                            r_spi_word <= spi_word(1'b0, w_entry.addr, w_entry.data);
                            r_state    <= S_WR_REQ;
                        end
                        OP_DELAY: r_state <= S_DELAY;
                        default: begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    endcase
                end
                S_WR_REQ: begin
                    if (!i_spi_busy) begin
                        r_wr_cmd  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_WR_BUSY;
                    end
                end
                S_WR_BUSY: begin
                    if (i_spi_busy) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_WR_DONE;
                    end else if (w_tmo_hit) begin
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_index <= r_tbl_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_WR_DONE: begin
                    if (!i_spi_busy) begin
                        if (r_op == OP_WRITE_VERIFY) begin
                            r_spi_word <= spi_word(1'b1, r_addr, 8'h00);
                            r_state    <= S_RD_REQ;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end else if (w_tmo_hit) begin
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_index <= r_tbl_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_RD_REQ: begin
                    if (!i_spi_busy) begin
                        r_rd_cmd  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_RD_BUSY;
                    end
                end
                S_RD_BUSY: begin
                    if (i_spi_busy) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_RD_DONE;
                    end else if (w_tmo_hit) begin
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_index <= r_tbl_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_RD_DONE: begin
                    if (!i_spi_busy) begin
                        r_rd_byte <= i_spi_rd_data;
                        r_state   <= S_CHECK;
                    end else if (w_tmo_hit) begin
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_index <= r_tbl_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_check_pass) begin
                        r_state <= S_NEXT;
                    end else if (w_retry_left) begin
                        r_rty_cnt  <= r_rty_cnt + RTY_W'(1);
                        r_spi_word <= spi_word(1'b0, r_addr, r_data);
                        r_state    <= S_WR_REQ;
                    end else begin
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_index <= r_tbl_addr;
                        r_state     <= S_ERROR;
                    end
                end
                S_DELAY: begin
                    if (w_dly_last) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + DLY_W'(1);
                    end
                end
                S_NEXT: begin
                    // Running off the end of the table is an implicit END.
                    if (r_tbl_addr == LAST_ADDR) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tbl_addr <= r_tbl_addr + TBL_AW'(1);
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_cfg_done    = r_done;
    assign o_cfg_err     = r_err;
    assign o_err_index   = r_err_index;
    assign o_tbl_addr    = r_tbl_addr;
    assign o_spi_wr_cmd  = r_wr_cmd;
    assign o_spi_rd_cmd  = r_rd_cmd;
    assign o_spi_wr_data = r_spi_word;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench for spi_reg_sequencer: a table-level reference model predicts
// the SPI command stream and final status; a monitor checks every command pulse.
module tb_spi_reg_sequencer;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BT    = 256;
    localparam int unsigned RTY   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          o_busy, o_cfg_done, o_cfg_err;
    logic [AW-1:0] o_err_index, o_tbl_addr;
    logic [31:0]   tbl_data;
    logic          o_spi_wr_cmd, o_spi_rd_cmd;
    logic [23:0]   o_spi_wr_data;
    logic [7:0]    spi_rd;
    logic          spi_busy;

    spi_reg_sequencer #(.TBL_AW(AW), .BUSY_TIMEOUT(BT), .VERIFY_RETRY(RTY)) dut (
        .clk(clk), .rst(rst), .i_cfg_start(start),
        .o_busy(o_busy), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
        .o_err_index(o_err_index), .o_tbl_addr(o_tbl_addr), .i_tbl_data(tbl_data),
        .o_spi_wr_cmd(o_spi_wr_cmd), .o_spi_rd_cmd(o_spi_rd_cmd),
        .o_spi_wr_data(o_spi_wr_data), .i_spi_rd_data(spi_rd), .i_spi_busy(spi_busy)
    );

    always #5 clk = ~clk;

    logic [31:0] tbl [DEPTH];
    always @(posedge clk) tbl_data <= tbl[o_tbl_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;
    logic [24:0] expq [$];
    logic [7:0]  flip [8192];
    logic [7:0]  mem  [8192];
    int wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, fall_cyc = 0, last_gap = 0;
    int spi_lat = 3, spi_len = 4;
    bit spi_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ent(input logic [1:0] op, input logic [12:0] a,
                                        input logic [7:0] d, input logic [7:0] m);
        return {op, 1'b0, a, d, m};
    endfunction

    // Monitor: every command pulse must match the head of the expected queue.
    logic [24:0] mon_got;
    initial forever begin
        @(negedge clk);
        if (o_spi_wr_cmd || o_spi_rd_cmd) begin
            mon_got = {o_spi_rd_cmd, o_spi_wr_data};
            if (o_spi_wr_cmd) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                last_gap = cyc - fall_cyc;
            end
            if (o_spi_rd_cmd) rd_cnt++;
            if (expq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_cmd: got %0h expected no command", mon_got);
            end else begin
                check("spi_cmd", 32'(mon_got), 32'(expq.pop_front()));
            end
        end
    end

    // spi_master model: busy rises spi_lat cycles after a command, lasts spi_len cycles.
    logic        m_rd;
    logic [23:0] m_word;
    initial begin
        spi_busy = 1'b0;
        spi_rd   = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_en && (o_spi_wr_cmd || o_spi_rd_cmd)) begin
                m_rd   = o_spi_rd_cmd;
                m_word = o_spi_wr_data;
                if (!m_rd) mem[m_word[20:8]] = m_word[7:0];
                repeat (spi_lat) @(negedge clk);
                spi_busy = 1'b1;
                repeat (spi_len) @(negedge clk);
                if (m_rd) spi_rd = mem[m_word[20:8]] ^ flip[m_word[20:8]];
                spi_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Reference model: walk the table, predict commands and final status.
    task automatic build_expect(output bit e_done, output bit e_err, output int e_idx);
        logic [1:0]  op;
        logic [12:0] a;
        logic [7:0]  d, m;
        bit pass;
        e_done = 1'b0; e_err = 1'b0; e_idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op = tbl[i][31:30]; a = tbl[i][28:16]; d = tbl[i][15:8]; m = tbl[i][7:0];
            if (op == 2'b11) begin e_done = 1'b1; return; end
            if (op == 2'b10) continue;
            if (op == 2'b00) begin expq.push_back({1'b0, 1'b0, 2'b00, a, d}); continue; end
            pass = 1'b0;
            for (int t = 0; t <= RTY && !pass; t++) begin
                expq.push_back({1'b0, 1'b0, 2'b00, a, d});
                expq.push_back({1'b1, 1'b1, 2'b00, a, 8'h00});
                pass = (((d ^ flip[a]) ^ d) & m) == 8'h00;
            end
            if (!pass) begin e_err = 1'b1; e_idx = i; return; end
        end
        e_done = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_table(input string tag, input int bound, input bit mid_start);
        bit e_done, e_err;
        int e_idx, n;
        expq.delete();
        build_expect(e_done, e_err, e_idx);
        pulse_start();
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        if (mid_start) begin
            repeat (6) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        n = 0;
        while (o_busy && n < bound) begin @(negedge clk); n++; end
        if (o_busy) begin
            n_vec++; n_miss++;
            $display("FAIL %s_finish: busy still high after %0d cycles", tag, n);
        end
        check({tag, "_done"}, 32'(o_cfg_done), 32'(e_done));
        check({tag, "_err"},  32'(o_cfg_err),  32'(e_err));
        if (e_err) check({tag, "_idx"}, 32'(o_err_index), 32'(e_idx));
        repeat (20) @(negedge clk);
        check({tag, "_drained"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < DEPTH; i++) tbl[i] = ent(2'b11, 13'h0, 8'h00, 8'h00);
        for (int i = 0; i < 8192; i++) begin flip[i] = 8'h00; mem[i] = 8'h00; end
    endtask

    int n, w0, err_cyc;

    initial begin
        rst = 1'b1; start = 1'b0;
        clear_tbl();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_cfg_done), 32'd0);
        check("rst_err",  32'(o_cfg_err), 32'd0);
        check("rst_idx",  32'(o_err_index), 32'd0);
        check("rst_addr", 32'(o_tbl_addr), 32'd0);
        check("rst_cmds", 32'({o_spi_wr_cmd, o_spi_rd_cmd}), 32'd0);
        check("rst_word", 32'(o_spi_wr_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two plain writes with a long busy, plus a start pulse mid-run.
        spi_len = 100;
        tbl[0] = ent(2'b00, 13'h010, 8'h7C, 8'h00);
        tbl[1] = ent(2'b00, 13'h232, 8'h01, 8'h00);
        run_table("two_writes", 2000, 1'b1);

        // Write-verify that reads back correctly.
        clear_tbl(); spi_len = 4;
        tbl[0] = ent(2'b01, 13'h01C, 8'h02, 8'hFF);
        run_table("verify_ok", 2000, 1'b0);

        // Write-verify that never matches: retries exhausted.
        clear_tbl();
        tbl[0] = ent(2'b01, 13'h01C, 8'h02, 8'hFF);
        flip[13'h01C] = 8'h02;
        w0 = wr_cnt; n = rd_cnt;
        run_table("verify_fail", 2000, 1'b0);
        check("verify_fail_wrs", 32'(wr_cnt - w0), 32'd3);
        check("verify_fail_rds", 32'(rd_cnt - n), 32'd3);

        // Mask 0x00 still reads but always passes.
        clear_tbl();
        tbl[0] = ent(2'b01, 13'h040, 8'hA5, 8'h00);
        flip[13'h040] = 8'hFF;
        run_table("mask_zero", 2000, 1'b0);

        // Delay of 1000 cycles between two writes.
        clear_tbl();
        tbl[0] = ent(2'b00, 13'h010, 8'h11, 8'h00);
        tbl[1] = 32'h8000_0000 | 32'd1000;
        tbl[2] = ent(2'b00, 13'h011, 8'h22, 8'h00);
        run_table("delay", 4000, 1'b0);
        n_vec++;
        if (last_gap < 998 || last_gap > 1010) begin
            n_miss++;
            $display("FAIL delay_gap: got %0d cycles expected about 1000", last_gap);
        end

        // Busy never rises: timeout after exactly BT cycles, no further commands.
        clear_tbl(); spi_en = 1'b0;
        tbl[0] = ent(2'b00, 13'h010, 8'h7C, 8'h00);
        tbl[1] = ent(2'b00, 13'h011, 8'h7D, 8'h00);
        expq.delete();
        expq.push_back({1'b0, 1'b0, 2'b00, 13'h010, 8'h7C});
        w0 = wr_cnt;
        pulse_start();
        n = 0;
        while (!o_cfg_err && n < 4 * BT) begin @(negedge clk); n++; end
        err_cyc = cyc;
        check("tmo_err", 32'(o_cfg_err), 32'd1);
        check("tmo_latency", 32'(err_cyc - last_wr_cyc), 32'(BT));
        check("tmo_idx", 32'(o_err_index), 32'd0);
        repeat (50) @(negedge clk);
        check("tmo_wr_count", 32'(wr_cnt - w0), 32'd1);
        spi_en = 1'b1;

        // Reset while waiting in RD_BUSY aborts everything.
        clear_tbl(); spi_len = 100;
        tbl[0] = ent(2'b01, 13'h020, 8'h55, 8'hFF);
        expq.delete();
        expq.push_back({1'b0, 1'b0, 2'b00, 13'h020, 8'h55});
        expq.push_back({1'b1, 1'b1, 2'b00, 13'h020, 8'h00});
        pulse_start();
        n = 0;
        while (!o_spi_rd_cmd && n < 2000) begin @(negedge clk); n++; end
        check("rst_mid_rd_seen", 32'(o_spi_rd_cmd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_flags", 32'({o_cfg_done, o_cfg_err}), 32'd0);
        check("rst_mid_addr", 32'(o_tbl_addr), 32'd0);
        check("rst_mid_word", 32'(o_spi_wr_data), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (200) @(negedge clk);
        check("rst_mid_drained", 32'(expq.size()), 32'd0);
        check("rst_mid_idle", 32'(o_busy), 32'd0);

        // Randomized tables against the reference model.
        for (int it = 0; it < 8; it++) begin
            clear_tbl();
            spi_len = int'($urandom_range(1, 6));
            spi_lat = int'($urandom_range(1, 4));
            for (int a = 0; a < 16; a++)
                if ($urandom_range(0, 3) == 0) flip[a] = 8'($urandom);
            for (int i = 0; i < DEPTH; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 40)
                    tbl[i] = ent(2'b00, 13'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                else if (r < 72)
                    tbl[i] = ent(2'b01, 13'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                else if (r < 90 || (it % 4) == 0)
                    tbl[i] = 32'h8000_0000 | 32'($urandom_range(0, 30));
                else
                    tbl[i] = ent(2'b11, 13'h0, 8'h00, 8'h00);
            end
            run_table($sformatf("rand%0d", it), 20000, (it % 3) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
